// File: rtl/sprite_cmd_pkg.sv
// Shared definitions for the sprite command generator: command word layout,
// opcodes, arbiter FSM states and a word-packing helper.
package sprite_cmd_pkg;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 29;
    localparam int X_MSB   = 28;
    localparam int X_LSB   = 19;
    localparam int Y_MSB   = 18;
    localparam int Y_LSB   = 9;
    localparam int OFS_MSB = 8;
    localparam int OFS_LSB = 0;

    localparam logic [2:0] OP_ACTIVE   = 3'b001;
    localparam logic [2:0] OP_INACTIVE = 3'b000;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    function automatic logic [31:0] make_cmd(input logic       active,
                                             input logic [9:0] x,
                                             input logic [9:0] y,
                                             input logic [8:0] ofs);
        logic [31:0] w;
        w                  = '0;
        w[OP_MSB:OP_LSB]   = active ? OP_ACTIVE : OP_INACTIVE;
        w[X_MSB:X_LSB]     = x;
        w[Y_MSB:Y_LSB]     = y;
        w[OFS_MSB:OFS_LSB] = ofs;
        return w;
    endfunction

endpackage

// File: rtl/sat_step_counter.sv
// 10-bit up/down counter that moves by STEP when enabled and saturates at
// [MIN, MAX]; 'changed' flags that the upcoming update alters the value.
module sat_step_counter #(
    parameter int MIN       = 0,
    parameter int MAX       = 1023,
    parameter int STEP      = 1,
    parameter int RESET_VAL = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       inc,
    input  logic       dec,
    output logic [9:0] value,
    output logic       changed
);

    localparam logic [10:0] MIN_W  = 11'(MIN);
    localparam logic [10:0] MAX_W  = 11'(MAX);
    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [9:0]  MIN_V  = 10'(MIN);
    localparam logic [9:0]  MAX_V  = 10'(MAX);
    localparam logic [9:0]  STEP_V = 10'(STEP);
    localparam logic [9:0]  RST_V  = 10'(RESET_VAL);

    logic [9:0]  value_q, value_d;
    logic [10:0] sum;
    logic [10:0] low_lim;

    // Decrement compares before subtracting so an underflow can never wrap.
    always_comb begin
        value_d = value_q;
        sum     = {1'b0, value_q} + STEP_W;
        low_lim = MIN_W + STEP_W;
        if (en && inc && !dec) begin
            value_d = (sum > MAX_W) ? MAX_V : sum[9:0];
        end else if (en && dec && !inc) begin
            value_d = ({1'b0, value_q} < low_lim) ? MIN_V : (value_q - STEP_V);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= RST_V;
        end else begin
            value_q <= value_d;
        end
    end

    assign value   = value_q;
    assign changed = (value_d != value_q);

endmodule

// File: rtl/sprite_cmd_gen.sv
// Multi-sprite position holder that emits one command word per changed sprite
// over a valid/ready link, picking dirty sprites round-robin.
module sprite_cmd_gen #(
    parameter int NUM_SPRITES = 4,
    parameter int X_MIN       = 1,
    parameter int X_MAX       = 620,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = 460,
    parameter int STEP        = 1,
    parameter int BASE_OFFSET = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [$clog2(NUM_SPRITES)-1:0] sel,
    input  logic                           btn_left,
    input  logic                           btn_right,
    input  logic                           btn_up,
    input  logic                           btn_down,
    input  logic                           btn_toggle,
    input  logic                           move_tick,
    input  logic                           cmd_ready,
    output logic                           cmd_valid,
    output logic [31:0]                    cmd_data
);

    import sprite_cmd_pkg::*;

    localparam int SW = $clog2(NUM_SPRITES);

    state_t                 state_q, state_d;
    logic                   cmd_valid_q, cmd_valid_d;
    logic [31:0]            cmd_data_q, cmd_data_d;
    logic [SW-1:0]          ptr_q, ptr_d;
    logic [SW-1:0]          chosen_q, chosen_d;
    logic [NUM_SPRITES-1:0] dirty_q, dirty_d;
    logic [NUM_SPRITES-1:0] active_q, active_d;
    logic                   toggle_q, toggle_d;

    logic                   sel_ok;
    logic                   tog_rise;
    logic [NUM_SPRITES-1:0] move_en, x_chg, y_chg, tog_hit, set_bits, clr_bits;
    logic [9:0]             x_val [NUM_SPRITES];
    logic [9:0]             y_val [NUM_SPRITES];

    logic                   found;
    logic [SW-1:0]          pick;
    int                     idx;

    assign sel_ok   = ({1'b0, sel} < (SW+1)'(NUM_SPRITES));
    assign tog_rise = btn_toggle & ~toggle_q;
    assign toggle_d = btn_toggle;

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_sprite
        assign move_en[i]  = move_tick & sel_ok & (sel == SW'(i));
        assign tog_hit[i]  = tog_rise & sel_ok & (sel == SW'(i));
        assign set_bits[i] = x_chg[i] | y_chg[i] | tog_hit[i];

        sat_step_counter #(
            .MIN(X_MIN), .MAX(X_MAX), .STEP(STEP), .RESET_VAL(X_MIN)
        ) u_x (
            .clk(clk), .reset(reset), .en(move_en[i]),
            .inc(btn_right), .dec(btn_left),
            .value(x_val[i]), .changed(x_chg[i])
        );

        sat_step_counter #(
            .MIN(Y_MIN), .MAX(Y_MAX), .STEP(STEP), .RESET_VAL(Y_MIN)
        ) u_y (
            .clk(clk), .reset(reset), .en(move_en[i]),
            .inc(btn_down), .dec(btn_up),
            .value(y_val[i]), .changed(y_chg[i])
        );
    end

    // Circular search for the first dirty sprite at or after the pointer.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 0; k < NUM_SPRITES; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_SPRITES) begin
                idx = idx - NUM_SPRITES;
            end
            if (!found && dirty_q[idx]) begin
                found = 1'b1;
                pick  = SW'(idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_valid_d = cmd_valid_q;
        cmd_data_d  = cmd_data_q;
        ptr_d       = ptr_q;
        chosen_d    = chosen_q;
        clr_bits    = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    cmd_data_d     = make_cmd(active_q[pick], x_val[pick], y_val[pick],
                                              9'(BASE_OFFSET) + 9'(pick));
                    clr_bits[pick] = 1'b1;
                    cmd_valid_d    = 1'b1;
                    chosen_d       = pick;
                    state_d        = SEND;
                end
            end
            SEND: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    ptr_d       = (chosen_q == SW'(NUM_SPRITES - 1)) ? '0 : chosen_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A fresh change outranks the clear so the newer position is re-sent.
        dirty_d  = (dirty_q & ~clr_bits) | set_bits;
        active_d = active_q ^ tog_hit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_valid_q <= 1'b0;
            cmd_data_q  <= '0;
            ptr_q       <= '0;
            chosen_q    <= '0;
            dirty_q     <= '1;
            active_q    <= '1;
            toggle_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_data_q  <= cmd_data_d;
            ptr_q       <= ptr_d;
            chosen_q    <= chosen_d;
            dirty_q     <= dirty_d;
            active_q    <= active_d;
            toggle_q    <= toggle_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_data  = cmd_data_q;

endmodule

// File: tb/tb_sprite_cmd_gen.sv
// Scoreboard bench for sprite_cmd_gen: stimulus pushes expected words, a
// negedge monitor pops and compares every word the DUT hands over.
module tb_sprite_cmd_gen;

    localparam int N     = 4;
    localparam int X_MIN = 1;
    localparam int X_MAX = 620;
    localparam int Y_MIN = 0;
    localparam int Y_MAX = 460;
    localparam int STEP  = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  sel = '0;
    logic        btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic        btn_toggle = 1'b0;
    logic        move_tick = 1'b0;
    logic        cmd_ready = 1'b1;
    logic        cmd_valid;
    logic [31:0] cmd_data;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    int          mx[N];
    int          my[N];
    bit          mact[N];

    sprite_cmd_gen #(
        .NUM_SPRITES(N), .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN),
        .Y_MAX(Y_MAX), .STEP(STEP), .BASE_OFFSET(0)
    ) dut (
        .clk(clk), .reset(reset), .sel(sel),
        .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
        .btn_toggle(btn_toggle), .move_tick(move_tick), .cmd_ready(cmd_ready),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_word(input int i);
        logic [31:0] w;
        w = {(mact[i] ? 3'b001 : 3'b000), 10'(mx[i]), 10'(my[i]), 9'(i)};
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < N; i++) begin
            mx[i]   = X_MIN;
            my[i]   = Y_MIN;
            mact[i] = 1'b1;
        end
    endtask

    task automatic pushAllInitial();
        for (int i = 0; i < N; i++) exp_q.push_back(exp_word(i));
    endtask

    // One move_tick with the given buttons; the model tracks the saturated position.
    task automatic applyStimulus(input int s, input bit l, input bit r, input bit u,
                                 input bit d, input bit push_exp);
        int nx, ny;
        @(posedge clk); #1;
        sel = 2'(s); btn_left = l; btn_right = r; btn_up = u; btn_down = d;
        move_tick = 1'b1;
        nx = mx[s];
        ny = my[s];
        if (r && !l)      nx = (mx[s] + STEP > X_MAX) ? X_MAX : mx[s] + STEP;
        else if (l && !r) nx = (mx[s] - STEP < X_MIN) ? X_MIN : mx[s] - STEP;
        if (d && !u)      ny = (my[s] + STEP > Y_MAX) ? Y_MAX : my[s] + STEP;
        else if (u && !d) ny = (my[s] - STEP < Y_MIN) ? Y_MIN : my[s] - STEP;
        if (nx != mx[s] || ny != my[s]) begin
            mx[s] = nx;
            my[s] = ny;
            if (push_exp) exp_q.push_back(exp_word(s));
        end
        @(posedge clk); #1;
        move_tick = 1'b0;
        btn_left = 1'b0; btn_right = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: %0d words outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic waitValid(input string name);
        int n;
        n = 0;
        while (!cmd_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: cmd_valid got 0, expected 1", name);
        end
    endtask

    // Every accepted word must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_word: got %h, expected no word", cmd_data);
            end else begin
                checkOutput("word", cmd_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        modelReset();
        #1;
        checkOutput("rst_valid", {31'b0, cmd_valid}, 32'h0);
        checkOutput("rst_data", cmd_data, 32'h0);

        // Reset release: initial states in index order.
        exp_q.push_back(32'h20080000);
        exp_q.push_back(32'h20080001);
        exp_q.push_back(32'h20080002);
        exp_q.push_back(32'h20080003);
        @(posedge clk); #1;
        reset = 1'b0;
        waitDrain("reset_words");

        // Sprite 2 moves right three times.
        for (int t = 0; t < 3; t++) begin
            applyStimulus(2, 0, 1, 0, 0, 1);
            waitDrain("move_right");
        end
        checkOutput("model_s2", exp_word(2), 32'h20200002);

        // Sprite 0 held against the left bound: nothing is sent.
        for (int t = 0; t < 5; t++) applyStimulus(0, 1, 0, 0, 0, 1);
        waitDrain("left_clamp");
        // Walk sprite 0 down to the bottom bound, then push once more.
        for (int t = 0; t < Y_MAX; t++) begin
            applyStimulus(0, 0, 0, 0, 1, 1);
            waitDrain("walk_down");
        end
        applyStimulus(0, 0, 0, 0, 1, 1);
        waitDrain("down_clamp");

        // Sprite 1 stalls in SEND while it keeps moving.
        cmd_ready = 1'b0;
        applyStimulus(1, 0, 1, 0, 0, 1);
        waitValid("stall_valid");
        checkOutput("hold0", cmd_data, 32'h20100001);
        applyStimulus(1, 0, 1, 0, 0, 0);
        checkOutput("hold1", cmd_data, 32'h20100001);
        applyStimulus(1, 0, 1, 0, 0, 0);
        checkOutput("hold2", cmd_data, 32'h20100001);
        checkOutput("hold_valid", {31'b0, cmd_valid}, 32'h1);
        exp_q.push_back(32'h20200001);
        @(posedge clk); #1;
        cmd_ready = 1'b1;
        waitDrain("stall_release");

        // Pointer parked at 3 with sprites 0 and 3 pending.
        applyStimulus(2, 0, 1, 0, 0, 1);
        waitDrain("ptr_setup");
        cmd_ready = 1'b0;
        applyStimulus(2, 0, 1, 0, 0, 1);
        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(3, 0, 1, 0, 0, 0);
        exp_q.push_back(32'h20100003);
        exp_q.push_back(32'h20139800);
        @(posedge clk); #1;
        cmd_ready = 1'b1;
        waitDrain("round_robin");
        applyStimulus(1, 1, 1, 0, 0, 1);
        waitDrain("both_buttons");

        // Toggle sprite 1 inactive.
        @(posedge clk); #1;
        sel = 2'd1;
        btn_toggle = 1'b1;
        mact[1] = 1'b0;
        exp_q.push_back(32'h00200001);
        @(posedge clk); #1;
        btn_toggle = 1'b0;
        waitDrain("toggle");

        // Reset while a word is pending drops it at once.
        cmd_ready = 1'b0;
        applyStimulus(3, 0, 1, 0, 0, 1);
        waitValid("pre_reset_valid");
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        checkOutput("async_valid", {31'b0, cmd_valid}, 32'h0);
        checkOutput("async_data", cmd_data, 32'h0);
        exp_q.delete();
        modelReset();
        pushAllInitial();
        cmd_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        waitDrain("post_reset_words");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
